// File: rtl/fft8_pkg.sv
// Shared constants, sample/frame types and index bit reversal for the
// 8-point radix-2 DIT FFT datapath.
package fft8_pkg;

    localparam int DW    = 9;
    localparam int N     = 8;
    localparam int LOG2N = $clog2(N);

    typedef logic signed [DW-1:0] sample_t;
    typedef sample_t [N-1:0]      frame_t;
    typedef logic [LOG2N-1:0]     idx_t;

    function automatic idx_t bitrev(input idx_t idx);
        idx_t r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = idx[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft8_input_reorder_if.sv
// Serial sample stream in, parallel reordered frame out, with
// independent valid/ready handshakes on each side.
interface fft8_input_reorder_if;
    import fft8_pkg::*;

    logic    in_valid;
    logic    in_ready;
    sample_t in_data;
    logic    in_first;
    logic    out_valid;
    logic    out_ready;
    frame_t  out_data;
    logic    sync_err;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_first,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output sync_err
    );

    modport master (
        output in_valid,
        output in_data,
        output in_first,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  sync_err
    );

endinterface

// File: rtl/fft8_input_reorder.sv
// FFT front end: writes serial samples at bit-reversed addresses into a
// ping-pong buffer and hands completed frames to the butterfly ranks.
module fft8_input_reorder
    import fft8_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    fft8_input_reorder_if.slave bus
);

    frame_t     bank [2];
    idx_t       wr_idx;
    logic       wbank;
    logic       rbank;
    logic [1:0] full;
    logic       sync_err_q;

    logic in_ready;
    logic out_valid;
    logic accept;
    logic resync;
    logic last;
    logic rel;
    idx_t waddr;

    always_comb begin
        in_ready  = !full[wbank];
        out_valid = full[rbank];
        accept    = bus.in_valid && in_ready;
        resync    = accept && bus.in_first && (wr_idx != '0);
        last      = accept && !resync && (wr_idx == idx_t'(N-1));
        rel       = out_valid && bus.out_ready;
        // A resync sample restarts the frame at arrival index 0
        waddr     = resync ? '0 : bitrev(wr_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx     <= '0;
            wbank      <= 1'b0;
            rbank      <= 1'b0;
            full       <= '0;
            sync_err_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                bank[b] <= '0;
            end
        end else begin
            sync_err_q <= resync;
            if (accept) begin
                bank[wbank][waddr] <= bus.in_data;
                if (resync) begin
                    wr_idx <= idx_t'(1);
                end else if (last) begin
                    wr_idx <= '0;
                end else begin
                    wr_idx <= wr_idx + idx_t'(1);
                end
            end
            // Fill and release always target different banks
            if (last) begin
                full[wbank] <= 1'b1;
                wbank       <= !wbank;
            end
            if (rel) begin
                full[rbank] <= 1'b0;
                rbank       <= !rbank;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = bank[rbank];
    assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_fft8_input_reorder.sv
// Directed bench for the FFT input reorder stage: ordering, extremes,
// backpressure, resync, simultaneous fill/release and async reset.
module tb_fft8_input_reorder;
    import fft8_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft8_input_reorder_if bus ();

    fft8_input_reorder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int ov_cycles = 0;
    int serr = 0;
    int rdy_low = 0;
    logic [N*DW-1:0] frames [$];

    int e_ord [N] = '{10, 14, 12, 16, 11, 15, 13, 17};
    int e_ext [N] = '{-256, 1, -1, 254, 255, -255, 0, -128};
    int e_bpa [N] = '{100, 104, 102, 106, 101, 105, 103, 107};
    int e_bpb [N] = '{108, 112, 110, 114, 109, 113, 111, 115};
    int e_rsy [N] = '{50, 54, 52, 56, 51, 55, 53, 57};
    int e_sma [N] = '{200, 204, 202, 206, 201, 205, 203, 207};
    int e_smb [N] = '{208, 212, 210, 214, 209, 213, 211, 215};
    int e_rst [N] = '{60, 64, 62, 66, 61, 65, 63, 67};
    int a_ext [N] = '{-256, 255, -1, 0, 1, -255, 254, -128};

    always @(negedge clk) begin
        if (bus.out_valid) ov_cycles++;
        if (bus.out_valid && bus.out_ready) frames.push_back(bus.out_data);
        if (bus.sync_err) serr++;
        if (!bus.in_ready) rdy_low++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int elem(input logic [N*DW-1:0] f, input int p);
        sample_t s;
        s = f[p*DW +: DW];
        return int'(s);
    endfunction

    task automatic chk_frame(input string tag, input logic [N*DW-1:0] f,
                             input int e [N]);
        for (int p = 0; p < N; p++) begin
            chk($sformatf("%s_p%0d", tag, p), elem(f, p), e[p]);
        end
    endtask

    task automatic send(input int v, input bit first);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = sample_t'(v);
        bus.in_first = first;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!bus.in_ready) begin
            chk("send_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    task automatic send_run(input int base, input int cnt, input bit first);
        for (int i = 0; i < cnt; i++) begin
            send(base + i, first && (i == 0));
        end
    endtask

    task automatic get_frame(input string tag, input int idx,
                             input int e [N]);
        if (frames.size() > idx) begin
            chk_frame(tag, frames[idx], e);
        end else begin
            chk({tag, "_missing"}, frames.size(), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov0;
        int rl0;
        int s0;
        int cnt;
        logic acc;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_first  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_sync_err", int'(bus.sync_err), 0);
        chk("rst_out_data", int'(|bus.out_data), 0);

        // Ordering
        bus.out_ready = 1'b1;
        frames.delete();
        ov0 = ov_cycles;
        rl0 = rdy_low;
        send_run(10, 8, 1'b1);
        chk("ord_latency_valid", int'(bus.out_valid), 1);
        chk_frame("ord_data", bus.out_data, e_ord);
        repeat (3) @(posedge clk);
        #1;
        chk("ord_valid_cycles", ov_cycles - ov0, 1);
        chk("ord_ready_low", rdy_low - rl0, 0);
        chk("ord_nframes", frames.size(), 1);
        get_frame("ord_frame", 0, e_ord);

        // Extremes
        frames.delete();
        for (int i = 0; i < N; i++) send(a_ext[i], i == 0);
        repeat (2) @(posedge clk);
        #1;
        chk("ext_nframes", frames.size(), 1);
        get_frame("ext", 0, e_ext);

        // Backpressure
        bus.out_ready = 1'b0;
        frames.delete();
        cnt = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            bus.in_data  = sample_t'(100 + cnt);
            bus.in_first = (cnt % 8 == 0);
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) cnt++;
        end
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        chk("bp_accepted", cnt, 16);
        chk("bp_in_ready", int'(bus.in_ready), 0);
        chk("bp_out_valid", int'(bus.out_valid), 1);
        chk_frame("bp_A", bus.out_data, e_bpa);
        repeat (3) @(posedge clk);
        #1;
        chk_frame("bp_A_hold", bus.out_data, e_bpa);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp_B_valid", int'(bus.out_valid), 1);
        chk_frame("bp_B", bus.out_data, e_bpb);
        chk("bp_ready_back", int'(bus.in_ready), 1);
        chk("bp_nframes_A", frames.size(), 1);
        get_frame("bp_relA", 0, e_bpa);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp_nframes_B", frames.size(), 2);
        get_frame("bp_relB", 1, e_bpb);
        chk("bp_empty", int'(bus.out_valid), 0);

        // Resync
        bus.out_ready = 1'b1;
        frames.delete();
        s0 = serr;
        send_run(40, 3, 1'b1);
        send(50, 1'b1);
        send_run(51, 7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rsy_pulses", serr - s0, 1);
        chk("rsy_nframes", frames.size(), 1);
        get_frame("rsy", 0, e_rsy);

        // Simultaneous fill-complete and release
        bus.out_ready = 1'b0;
        frames.delete();
        rl0 = rdy_low;
        send_run(200, 8, 1'b1);
        send_run(208, 7, 1'b1);
        bus.out_ready = 1'b1;
        send(215, 1'b0);
        chk("sim_B_valid", int'(bus.out_valid), 1);
        chk_frame("sim_B_now", bus.out_data, e_smb);
        chk("sim_nframes1", frames.size(), 1);
        get_frame("sim_A", 0, e_sma);
        @(posedge clk);
        #1;
        chk("sim_nframes2", frames.size(), 2);
        get_frame("sim_B", 1, e_smb);
        chk("sim_empty", int'(bus.out_valid), 0);
        chk("sim_ready_low", rdy_low - rl0, 0);

        // Async reset mid-frame
        bus.out_ready = 1'b0;
        send_run(120, 8, 1'b1);
        send_run(1, 3, 1'b1);
        chk("ar_pre_valid", int'(bus.out_valid), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", int'(bus.out_valid), 0);
        chk("ar_in_ready", int'(bus.in_ready), 1);
        chk("ar_out_data", int'(|bus.out_data), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        frames.delete();
        send_run(60, 8, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("ar_nframes", frames.size(), 1);
        get_frame("ar_fresh", 0, e_rst);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
